// File: rtl/frame_latency_meter_if.sv
// rtl/frame_latency_meter_if.sv - strobe, status and statistics bundle of the frame latency meter
interface frame_latency_meter_if #(
  parameter int CNT_W = 20,
  parameter int ACC_W = 32,
  parameter int NUM_W = 16
);
  logic             frame_sent;
  logic             frame_caught;
  logic             clear_stats;
  logic             busy;
  logic             done;
  logic             timed_out;
  logic [CNT_W-1:0] time_out;
  logic [CNT_W-1:0] last_delay;
  logic [CNT_W-1:0] min_delay;
  logic [CNT_W-1:0] max_delay;
  logic [ACC_W-1:0] delay_sum;
  logic [NUM_W-1:0] sample_count;
  logic [NUM_W-1:0] timeout_count;

  modport master (
    output frame_sent, frame_caught, clear_stats,
    input  busy, done, timed_out, time_out, last_delay, min_delay, max_delay,
           delay_sum, sample_count, timeout_count
  );

  modport slave (
    input  frame_sent, frame_caught, clear_stats,
    output busy, done, timed_out, time_out, last_delay, min_delay, max_delay,
           delay_sum, sample_count, timeout_count
  );
endinterface

// File: rtl/frame_latency_meter.sv
// rtl/frame_latency_meter.sv - frame round-trip latency meter with timeout and running statistics
module frame_latency_meter #(
  parameter int CNT_W   = 20,
  parameter int TIMEOUT = 1000000,
  parameter int ACC_W   = 32,
  parameter int NUM_W   = 16
) (
  input logic                 tx_clk,
  input logic                 reset,
  frame_latency_meter_if.slave bus
);
  localparam int SUM_W = ((ACC_W > CNT_W) ? ACC_W : CNT_W) + 1;

  typedef enum logic {IDLE, COUNT} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] last_q, last_d;
  logic [CNT_W-1:0] min_q, min_d;
  logic [CNT_W-1:0] max_q, max_d;
  logic [ACC_W-1:0] sum_q, sum_d;
  logic [NUM_W-1:0] samples_q, samples_d;
  logic [NUM_W-1:0] touts_q, touts_d;
  logic             done_q, done_d;
  logic             to_q, to_d;
  logic [CNT_W-1:0] cnt_inc;
  logic [SUM_W-1:0] sum_wide;

  // cnt_inc is both the next count and the delay of a catch on this edge
  assign cnt_inc  = cnt_q + CNT_W'(1);
  assign sum_wide = SUM_W'(sum_q) + SUM_W'(cnt_inc);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    min_d     = min_q;
    max_d     = max_q;
    sum_d     = sum_q;
    samples_d = samples_q;
    touts_d   = touts_q;
    done_d    = 1'b0;
    to_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.frame_sent) begin
          state_d = COUNT;
          cnt_d   = '0;
        end
      end
      COUNT: begin
        cnt_d = cnt_inc;
        if (bus.frame_caught) begin
          state_d   = IDLE;
          done_d    = 1'b1;
          last_d    = cnt_inc;
          samples_d = (&samples_q) ? samples_q : samples_q + NUM_W'(1);
          sum_d     = (|sum_wide[SUM_W-1:ACC_W]) ? '1 : sum_wide[ACC_W-1:0];
          if (cnt_inc < min_q) min_d = cnt_inc;
          if (cnt_inc > max_q) max_d = cnt_inc;
        end else if (cnt_inc == CNT_W'(TIMEOUT)) begin
          state_d = IDLE;
          to_d    = 1'b1;
          touts_d = (&touts_q) ? touts_q : touts_q + NUM_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // a coincident completion still pulses and updates last_delay, but is not counted
    if (bus.clear_stats) begin
      min_d     = '1;
      max_d     = '0;
      sum_d     = '0;
      samples_d = '0;
      touts_d   = '0;
    end
  end

  always_ff @(posedge tx_clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      last_q    <= '0;
      min_q     <= '1;
      max_q     <= '0;
      sum_q     <= '0;
      samples_q <= '0;
      touts_q   <= '0;
      done_q    <= 1'b0;
      to_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      min_q     <= min_d;
      max_q     <= max_d;
      sum_q     <= sum_d;
      samples_q <= samples_d;
      touts_q   <= touts_d;
      done_q    <= done_d;
      to_q      <= to_d;
    end
  end

  assign bus.busy          = (state_q == COUNT);
  assign bus.done          = done_q;
  assign bus.timed_out     = to_q;
  assign bus.time_out      = cnt_q;
  assign bus.last_delay    = last_q;
  assign bus.min_delay     = min_q;
  assign bus.max_delay     = max_q;
  assign bus.delay_sum     = sum_q;
  assign bus.sample_count  = samples_q;
  assign bus.timeout_count = touts_q;
endmodule
